// File: rtl/button_pkg.sv
// Shared types and constants for the button event path.
package button_pkg;

  // FSM state encoding; ARM waits for the button to be seen released first.
  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PRESSED = 2'd2,
    ST_HELD    = 2'd3
  } state_t;

  localparam int PRESS_CNT_W       = 8;
  localparam int DEF_HOLD_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 10_000_000;
  localparam int DEF_CNT_W         = 26;

  // Press counter update: a clear takes effect before the increment.
  function automatic logic [PRESS_CNT_W-1:0] count_next(
    input logic [PRESS_CNT_W-1:0] cur,
    input logic                   clr,
    input logic                   inc
  );
    logic [PRESS_CNT_W-1:0] base;
    base = clr ? '0 : cur;
    return base + PRESS_CNT_W'(inc);
  endfunction

endpackage

// File: rtl/button_timer.sv
// Up-counter shared by the PRESSED and HELD phases; the terminal value is
// supplied by the owner so one counter serves both thresholds.
module button_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] terminal,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // done is a combinational strobe in the cycle the counter sits on terminal.
  assign done = en && (count == terminal);

  // Counter: clear wins, wrap to zero on terminal, otherwise count while enabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr || done) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/button_event.sv
// Turns the debounced button level into single-cycle press/release/click/
// hold/repeat events, a held level and a wrapping press counter.
module button_event
  import button_pkg::*;
#(
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   btn_level,
  input  logic                   repeat_en,
  input  logic                   count_clr,
  output logic                   press_pulse,
  output logic                   release_pulse,
  output logic                   click_pulse,
  output logic                   hold_pulse,
  output logic                   repeat_pulse,
  output logic                   held,
  output logic [PRESS_CNT_W-1:0] press_count,
  output logic [1:0]             state_dbg
);

  localparam logic [CNT_W-1:0] HOLD_TERM   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic             press_d;
  logic             release_d;
  logic             click_d;
  logic             hold_d;
  logic             repeat_d;
  logic             timer_clr;
  logic             timer_en;
  logic             timer_done;
  logic [CNT_W-1:0] terminal;

  assign state_dbg = state;

  // Terminal value depends on which timed phase the FSM is in.
  always_comb begin
    terminal = (state == ST_HELD) ? REPEAT_TERM : HOLD_TERM;
  end

  button_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (timer_clr),
    .en       (timer_en),
    .terminal (terminal),
    .done     (timer_done)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_ARM;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and event decode; a release always beats a terminal count.
  always_comb begin
    next_state = state;
    press_d    = 1'b0;
    release_d  = 1'b0;
    click_d    = 1'b0;
    hold_d     = 1'b0;
    repeat_d   = 1'b0;
    case (state)
      ST_ARM: begin
        if (!btn_level) next_state = ST_IDLE;
      end
      ST_IDLE: begin
        if (btn_level) begin
          next_state = ST_PRESSED;
          press_d    = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!btn_level) begin
          next_state = ST_IDLE;
          release_d  = 1'b1;
          click_d    = 1'b1;
        end else if (timer_done) begin
          next_state = ST_HELD;
          hold_d     = 1'b1;
        end
      end
      ST_HELD: begin
        if (!btn_level) begin
          next_state = ST_IDLE;
          release_d  = 1'b1;
        end else if (timer_done) begin
          repeat_d = repeat_en;
        end
      end
      default: next_state = ST_ARM;
    endcase
  end

  // Timer runs only in the timed phases and restarts on every state change.
  always_comb begin
    timer_en  = (state == ST_PRESSED) || (state == ST_HELD);
    timer_clr = (next_state != state);
  end

  // Registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      hold_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
      press_count   <= '0;
    end else begin
      press_pulse   <= press_d;
      release_pulse <= release_d;
      click_pulse   <= click_d;
      hold_pulse    <= hold_d;
      repeat_pulse  <= repeat_d;
      held          <= (next_state == ST_HELD);
      press_count   <= count_next(press_count, count_clr, press_d);
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event with short hold/repeat thresholds.
module tb_button_event;

  localparam int H = 8;
  localparam int R = 4;

  logic       clock;
  logic       reset_n;
  logic       btn_level;
  logic       repeat_en;
  logic       count_clr;
  logic       press_pulse;
  logic       release_pulse;
  logic       click_pulse;
  logic       hold_pulse;
  logic       repeat_pulse;
  logic       held;
  logic [7:0] press_count;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mode 0 = waiting for first release, 1 = up, 2 = down.
  int         m_mode;
  int         m_dur;
  logic [7:0] m_cnt;
  logic       e_press, e_rel, e_click, e_hold, e_rep, e_held;

  button_event #(
    .HOLD_CYCLES   (H),
    .REPEAT_CYCLES (R),
    .CNT_W         (4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .btn_level     (btn_level),
    .repeat_en     (repeat_en),
    .count_clr     (count_clr),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .click_pulse   (click_pulse),
    .hold_pulse    (hold_pulse),
    .repeat_pulse  (repeat_pulse),
    .held          (held),
    .press_count   (press_count),
    .state_dbg     (state_dbg)
  );

  // Clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] obs_vec();
    return {state_dbg, press_count, held, repeat_pulse, hold_pulse,
            click_pulse, release_pulse, press_pulse};
  endfunction

  function automatic logic [15:0] exp_vec();
    logic [1:0] st;
    if (m_mode == 0)      st = 2'd0;
    else if (m_mode == 1) st = 2'd1;
    else if (m_dur < H)   st = 2'd2;
    else                  st = 2'd3;
    return {st, m_cnt, e_held, e_rep, e_hold, e_click, e_rel, e_press};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_dur = 0; m_cnt = 8'd0;
    e_press = 0; e_rel = 0; e_click = 0; e_hold = 0; e_rep = 0; e_held = 0;
  endtask

  // Outputs expected after one edge, from press duration arithmetic.
  task automatic model_update(input logic b, input logic r, input logic c);
    e_press = 0; e_rel = 0; e_click = 0; e_hold = 0; e_rep = 0;
    case (m_mode)
      0: if (!b) m_mode = 1;
      1: if (b) begin m_mode = 2; m_dur = 0; e_press = 1; end
      default: begin
        m_dur++;
        if (!b) begin
          e_rel = 1; e_click = (m_dur <= H); m_mode = 1;
        end else begin
          if (m_dur == H) e_hold = 1;
          if (m_dur > H && ((m_dur - H) % R) == 0 && r) e_rep = 1;
        end
      end
    endcase
    e_held = (m_mode == 2) && (m_dur >= H);
    if (c) m_cnt = 8'd0;
    if (e_press) m_cnt = m_cnt + 8'd1;
  endtask

  // Driver: apply inputs, take one edge, advance the model, settle.
  task automatic step(input logic b, input logic r, input logic c);
    btn_level = b; repeat_en = r; count_clr = c;
    @(posedge clock);
    model_update(b, r, c);
    #1;
  endtask

  task automatic apply_reset(input logic b);
    btn_level = b; repeat_en = 0; count_clr = 0;
    reset_n = 0;
    model_reset();
    @(posedge clock); #1;
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs_vec(), exp_vec());
    end
    @(posedge clock); #1;
    reset_n = 1;
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
    for (int i = 0; i < 22; i++) begin
      step((i < 20) ? 1'b1 : ((i == 20) ? 1'b0 : 1'b1), 1'b0, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_held_button cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (press_pulse !== 1'b1 || press_count !== 8'd1) begin
      n_fail++;
      $display("FAIL reset_second_press: got press=%b count=%0d expected press=1 count=1", press_pulse, press_count);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_click();
    apply_reset(1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= 3; i++) begin
      step((i < 3) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL click cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if ({release_pulse, click_pulse, hold_pulse} !== 3'b110 || press_count !== 8'd1) begin
      n_fail++;
      $display("FAIL click_release: got rel/click/hold=%b%b%b count=%0d expected 110 count=1",
               release_pulse, click_pulse, hold_pulse, press_count);
    end
  endtask

  task automatic test_hold_repeat(input logic rep);
    for (int i = 0; i <= 20; i++) begin
      step((i < 20) ? 1'b1 : 1'b0, rep, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL hold_repeat(%b) cyc %0d: got %h expected %h", rep, i, obs_vec(), exp_vec());
      end
      if (i == H) begin
        n_checks++;
        if (hold_pulse !== 1'b1 || held !== 1'b1) begin
          n_fail++;
          $display("FAIL hold_edge: got hold=%b held=%b expected 1 1", hold_pulse, held);
        end
      end
      if (i == H + R || i == H + 2 * R) begin
        n_checks++;
        if (repeat_pulse !== rep) begin
          n_fail++;
          $display("FAIL repeat_edge k+%0d: got %b expected %b", i, repeat_pulse, rep);
        end
      end
    end
    n_checks++;
    if ({release_pulse, click_pulse, held} !== 3'b100) begin
      n_fail++;
      $display("FAIL hold_release: got rel/click/held=%b%b%b expected 100", release_pulse, click_pulse, held);
    end
  endtask

  task automatic test_release_at_threshold();
    for (int i = 0; i <= H; i++) begin
      step((i < H) ? 1'b1 : 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL threshold cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if ({release_pulse, click_pulse, hold_pulse, held} !== 4'b1100) begin
      n_fail++;
      $display("FAIL threshold_release: got rel/click/hold/held=%b%b%b%b expected 1100",
               release_pulse, click_pulse, hold_pulse, held);
    end
  endtask

  task automatic test_wrap();
    apply_reset(1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap press %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (press_count !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d expected 0", press_count);
    end
    step(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (press_count !== 8'd1 || press_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_with_press: got count=%0d press=%b expected 1 1", press_count, press_pulse);
    end
    step(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (press_count !== 8'd0) begin
      n_fail++;
      $display("FAIL clr_alone: got %0d expected 0", press_count);
    end
  endtask

  task automatic test_reset_mid_hold();
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i <= 10; i++) step(1'b1, 1'b1, 1'b0);
    reset_n = 0;
    model_reset();
    #1;
    n_checks++;
    if (obs_vec() !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_hold_reset: got %h expected 0000", obs_vec());
    end
    @(posedge clock); #1;
    reset_n = 1;
    for (int i = 0; i < 7; i++) begin
      step((i < 5) ? 1'b1 : ((i == 5) ? 1'b0 : 1'b1), 1'b1, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL after_reset cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (press_pulse !== 1'b1 || press_count !== 8'd1) begin
      n_fail++;
      $display("FAIL after_reset_press: got press=%b count=%0d expected 1 1", press_pulse, press_count);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic b, r, c;
    int   run;
    b = 0; r = 1; run = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run == 0) begin
        b   = ~b;
        run = b ? $urandom_range(1, 22) : $urandom_range(1, 5);
      end
      run--;
      if ($urandom_range(0, 9) == 0) r = ~r;
      c = ($urandom_range(0, 24) == 0);
      step(b, r, c);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    reset_n = 0; btn_level = 0; repeat_en = 0; count_clr = 0;
    model_reset();
    test_reset();
    test_click();
    test_hold_repeat(1'b1);
    test_hold_repeat(1'b0);
    test_release_at_threshold();
    test_wrap();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Consumer end of the button path: takes the debounced button level and turns it into single-cycle events (press, release, short click, long hold, auto-repeat) plus a wrapping press counter.
- Sits directly downstream of the button debouncer.
- Feeds UI/mode logic of the VGA display driver, e.g. pattern select and position stepping.

Parameters:
- HOLD_CYCLES, 50_000_000, cycles the button must stay pressed before hold_pulse (0.5 s at 100 MHz); legal range >= 2.
- REPEAT_CYCLES, 10_000_000, cycle period of repeat_pulse while held; legal range >= 2.
- CNT_W, 26, timer width; must satisfy 2^CNT_W > max(HOLD_CYCLES, REPEAT_CYCLES).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- btn_level  in  1  debounced button level, 1 = pressed; synchronous to clock
- repeat_en  in  1  1 = emit repeat_pulse while in HELD
- count_clr  in  1  synchronous clear of press_count
- press_pulse  out  1  one-cycle pulse on an accepted press
- release_pulse  out  1  one-cycle pulse on release from PRESSED or HELD
- click_pulse  out  1  one-cycle pulse on release before hold threshold
- hold_pulse  out  1  one-cycle pulse when hold threshold is reached
- repeat_pulse  out  1  one-cycle pulse every REPEAT_CYCLES while held
- held  out  1  level, 1 while in HELD
- press_count  out  8  number of press_pulse events, wraps 255->0

Behaviour:
- Reset (async assert, sync-to-clock release):
  - State = ARM, timer = 0.
  - All pulse outputs = 0, held = 0, press_count = 0.
- All outputs are registered. "Event at edge k" means the output is high for exactly the cycle following edge k.
- ARM:
  - Ignores presses until btn_level = 0 is sampled, then moves to IDLE.
  - A button already held at reset release produces no events.
- IDLE:
  - btn_level = 1 at edge k -> PRESSED.
  - press_pulse at edge k.
  - timer = 0.
  - press_count += 1.
- PRESSED: timer increments each edge.
  - btn_level = 0 -> IDLE, with release_pulse and click_pulse at the same edge.
  - Otherwise, when timer = HOLD_CYCLES-1 -> HELD, with hold_pulse and timer = 0.
  - Result: hold_pulse fires at edge k+HOLD_CYCLES after the press edge k.
- HELD: timer increments each edge.
  - btn_level = 0 -> IDLE, with release_pulse only (no click_pulse).
  - Otherwise, when timer = REPEAT_CYCLES-1: timer = 0, and repeat_pulse fires if repeat_en = 1.
  - Repeat pulses land at edges k+HOLD_CYCLES+n*REPEAT_CYCLES, n >= 1.
- held = 1 exactly while state = HELD. Registered, so it rises with hold_pulse and falls with release_pulse.
- Simultaneous events:
  - Release sampled on the same edge the timer hits terminal: release wins. No hold_pulse or repeat_pulse.
  - count_clr with press_pulse at the same edge: press_count = 1 (clear first, then increment).
  - count_clr alone: press_count = 0 at that edge.
- repeat_en is sampled only at the terminal edge. Toggling it mid-period does not reset the timer.
- Pulses are mutually exclusive except release_pulse + click_pulse.
- press_count arithmetic is modulo 256.
- Reset asserted mid-hold: immediate return to ARM with all outputs 0. After release, the still-pressed button is ignored until released.
- State encoding: 2 bits. ARM = 0, IDLE = 1, PRESSED = 2, HELD = 3.

Decomposition:
- Package button_pkg:
  - state enum (ARM, IDLE, PRESSED, HELD)
  - PRESS_CNT_W = 8
  - default HOLD/REPEAT constants
- Sub-module button_timer: CNT_W up-counter with sync clear and terminal-compare input; outputs a `done` strobe. Instantiated once and shared by PRESSED and HELD, since the terminal value is muxed by state.
- FSM and outputs live in button_event.

Test Plan (HOLD_CYCLES = 8, REPEAT_CYCLES = 4):
- Reset with btn_level = 1, hold 20 cycles, release, press again:
  - No events during the first press.
  - Second press gives press_pulse and press_count = 1.
- Press for 3 cycles, then release:
  - press_pulse at edge k.
  - release_pulse + click_pulse at edge k+3.
  - No hold_pulse; press_count = 1.
- Press for 20 cycles, repeat_en = 1:
  - hold_pulse at k+8; held = 1.
  - repeat_pulse at k+12 and k+16.
  - release_pulse (no click_pulse) at release edge; held = 0.
- Same as above with repeat_en = 0: hold_pulse at k+8, no repeat_pulse.
- Release sampled exactly at edge k+8: release_pulse + click_pulse, no hold_pulse, held stays 0.
- 256 short presses, then count_clr coincident with press 257:
  - press_count wraps to 0 after press 256.
  - press_count reads 1 after the coincident edge.
- Reset asserted at k+10 while held: outputs 0 immediately; no events until a release then a new press.
